// File: rtl/fpjh_pkg.sv
// Shared constants and helpers for the fpjh fragmentation framer.
// Holds FSM state codes, header field geometry and keep/byte-mask helpers.
package fpjh_pkg;

    localparam int unsigned LEN_W   = 12;
    localparam int unsigned IDX_W   = 7;
    localparam int unsigned AGG_BIT = 0;

    localparam logic [31:0] TAIL_WORD_DEF = 32'hEB90_0000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR0    = 3'd1;
    localparam logic [2:0] ST_HDR1    = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_TAIL    = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

    // Byte-lane mask for an MSB-contiguous keep.
    function automatic logic [31:0] byte_mask(input logic [3:0] keep);
        return {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
    endfunction

    // Number of valid bytes in an MSB-contiguous keep.
    function automatic logic [2:0] keep_count(input logic [3:0] keep);
        case (keep)
            4'b1000: return 3'd1;
            4'b1100: return 3'd2;
            4'b1110: return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/fpjh_tail_merge.sv
// Combinational byte packer: folds the tail word behind the k valid bytes of
// the last payload beat and returns the spill-over beat with its keep.
//   k           : valid payload bytes in the last beat (1..4)
//   beat        : last payload beat, unused lanes already zero
//   tail        : tail word, MSB byte first
//   merged_c    : payload bytes followed by the first 4-k tail bytes
//   left_c      : remaining k tail bytes, MSB aligned
//   left_keep_c : keep for left_c
module fpjh_tail_merge
    import fpjh_pkg::*;
(
    input  logic [2:0]  k,
    input  logic [31:0] beat,
    input  logic [31:0] tail,
    output logic [31:0] merged_c,
    output logic [31:0] left_c,
    output logic [3:0]  left_keep_c
);

    always_comb begin
        merged_c    = beat;
        left_c      = tail;
        left_keep_c = 4'b1111;
        case (k)
            3'd1: begin
                merged_c    = {beat[31:24], tail[31:8]};
                left_c      = {tail[7:0], 24'h0};
                left_keep_c = 4'b1000;
            end
            3'd2: begin
                merged_c    = {beat[31:16], tail[31:16]};
                left_c      = {tail[15:0], 16'h0};
                left_keep_c = 4'b1100;
            end
            3'd3: begin
                merged_c    = {beat[31:8], tail[31:24]};
                left_c      = {tail[23:0], 8'h0};
                left_keep_c = 4'b1110;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fpjh_frag_send.sv
// Transmit fragmentation framer: cuts one AXIS packet into fragments of at
// most FRAG_MAX bytes, prefixes the fpjh header and appends the tail word.
//   clk, rst           : clock, synchronous active-high reset
//   i_axis_*, i_pkt_len, i_frame_type : packet input with length/type sideband
//   o_axis_*           : framed output through a single holding register
//   o_err              : one-cycle pulse on packet length mismatch
//   o_busy             : high while a packet is in progress
module fpjh_frag_send
    import fpjh_pkg::*;
#(
    parameter int unsigned FRAG_MAX  = 840,
    parameter logic [31:0] TAIL_WORD = TAIL_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_axis_tvalid,
    input  logic [31:0] i_axis_tdata,
    input  logic [3:0]  i_axis_tkeep,
    input  logic        i_axis_tlast,
    output logic        i_axis_tready,
    input  logic [11:0] i_pkt_len,
    input  logic [15:0] i_frame_type,
    output logic        o_axis_tvalid,
    output logic [31:0] o_axis_tdata,
    output logic [3:0]  o_axis_tkeep,
    output logic        o_axis_tlast,
    input  logic        o_axis_tready,
    output logic        o_err,
    output logic        o_busy
);

    localparam logic [LEN_W-1:0] FRAG_MAX_L = LEN_W'(FRAG_MAX);

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d, cnt_q, cnt_d, off_q, off_d;
    logic [14:0]      type_q, type_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             short_q, short_d, long_q, long_d;
    logic [31:0]      left_q, left_d;
    logic [3:0]       left_keep_q, left_keep_d;
    logic             ovalid_q, ovalid_d, olast_q, olast_d;
    logic [31:0]      odata_q, odata_d;
    logic [3:0]       okeep_q, okeep_d;
    logic             err_q, err_d, busy_q, busy_d;

    logic             load, hdr_agg, last_beat, short_hit, long_hit;
    logic [LEN_W-1:0] hdr_tot, hdr_rem, hdr_flen;
    logic [14:0]      hdr_type;
    logic [IDX_W-1:0] hdr_idx;
    logic [2:0]       nb, kc;
    logic [31:0]      pay_data, merged, left;
    logic [3:0]       left_keep;
    logic             unused_type_lsb;

    assign unused_type_lsb = i_frame_type[0];

    assign load          = !ovalid_q || o_axis_tready;
    assign i_axis_tready = (state_q == ST_PAYLOAD && load && !short_q) || state_q == ST_DRAIN;

    // Header fields come straight from the sideband when a packet starts in IDLE.
    assign hdr_tot  = (state_q == ST_IDLE) ? i_pkt_len : len_q;
    assign hdr_rem  = (state_q == ST_IDLE) ? i_pkt_len : rem_q;
    assign hdr_type = (state_q == ST_IDLE) ? i_frame_type[15:1] : type_q;
    assign hdr_idx  = (state_q == ST_IDLE) ? IDX_W'(0) : idx_q;
    assign hdr_agg  = hdr_tot > FRAG_MAX_L;
    assign hdr_flen = (hdr_rem > FRAG_MAX_L) ? FRAG_MAX_L : hdr_rem;

    // Declared bytes in this beat; after a short packet the beat is zero padding.
    assign last_beat = cnt_q <= LEN_W'(4);
    assign nb        = last_beat ? cnt_q[2:0] : 3'd4;
    assign kc        = keep_count(i_axis_tkeep);
    assign pay_data  = short_q ? 32'h0 : (i_axis_tdata & byte_mask(i_axis_tkeep));
    assign short_hit = i_axis_tlast && (!last_beat || rem_q != '0 || kc < nb);
    assign long_hit  = !i_axis_tlast && last_beat && rem_q == '0;

    fpjh_tail_merge u_merge (
        .k           (nb),
        .beat        (pay_data),
        .tail        (TAIL_WORD),
        .merged_c    (merged),
        .left_c      (left),
        .left_keep_c (left_keep)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        type_d      = type_q;
        idx_d       = idx_q;
        short_d     = short_q;
        long_d      = long_q;
        left_d      = left_q;
        left_keep_d = left_keep_q;
        ovalid_d    = load ? 1'b0 : ovalid_q;
        odata_d     = odata_q;
        okeep_d     = okeep_q;
        olast_d     = olast_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE, ST_HDR0: begin
                if (load && (state_q == ST_HDR0 || i_axis_tvalid)) begin
                    ovalid_d = 1'b1;
                    odata_d  = {4'h0, hdr_flen, hdr_type, hdr_agg};
                    okeep_d  = 4'b1111;
                    olast_d  = 1'b0;
                    len_d    = hdr_tot;
                    type_d   = hdr_type;
                    rem_d    = hdr_rem - hdr_flen;
                    cnt_d    = hdr_flen;
                    off_d    = hdr_tot - hdr_rem;
                    idx_d    = hdr_idx;
                    if (state_q == ST_IDLE) begin
                        short_d = 1'b0;
                        long_d  = 1'b0;
                    end
                    state_d = hdr_agg ? ST_HDR1 : ST_PAYLOAD;
                end
            end
            ST_HDR1: begin
                if (load) begin
                    ovalid_d = 1'b1;
                    odata_d  = {idx_q, rem_q == '0, 12'h000, off_q};
                    okeep_d  = 4'b1111;
                    olast_d  = 1'b0;
                    state_d  = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (load && (short_q || i_axis_tvalid)) begin
                    ovalid_d = 1'b1;
                    okeep_d  = 4'b1111;
                    olast_d  = 1'b0;
                    cnt_d    = cnt_q - LEN_W'(nb);
                    if (last_beat) begin
                        odata_d     = merged;
                        left_d      = left;
                        left_keep_d = left_keep;
                        state_d     = ST_TAIL;
                    end else begin
                        odata_d = pay_data;
                    end
                    if (!short_q) begin
                        err_d   = short_hit || long_hit;
                        short_d = short_hit;
                        long_d  = long_hit;
                    end
                end
            end
            ST_TAIL: begin
                if (load) begin
                    ovalid_d = 1'b1;
                    odata_d  = left_q;
                    okeep_d  = left_keep_q;
                    olast_d  = 1'b1;
                    if (rem_q != '0) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_HDR0;
                    end else begin
                        state_d = long_q ? ST_DRAIN : ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (i_axis_tvalid && i_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = state_d != ST_IDLE;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            off_q       <= '0;
            type_q      <= '0;
            idx_q       <= '0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            left_q      <= '0;
            left_keep_q <= '0;
            ovalid_q    <= 1'b0;
            odata_q     <= '0;
            okeep_q     <= '0;
            olast_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            type_q      <= type_d;
            idx_q       <= idx_d;
            short_q     <= short_d;
            long_q      <= long_d;
            left_q      <= left_d;
            left_keep_q <= left_keep_d;
            ovalid_q    <= ovalid_d;
            odata_q     <= odata_d;
            okeep_q     <= okeep_d;
            olast_q     <= olast_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign o_axis_tvalid = ovalid_q;
    assign o_axis_tdata  = odata_q;
    assign o_axis_tkeep  = okeep_q;
    assign o_axis_tlast  = olast_q;
    assign o_err         = err_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_fpjh_frag_send.sv
// Testbench for fpjh_frag_send: directed and random packets compared against
// a byte-level frame model built from the frame format rules.
module tb_fpjh_frag_send;

    localparam int FM = 840;
    localparam logic [31:0] TAIL = 32'hEB90_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_axis_tvalid, i_axis_tlast, i_axis_tready;
    logic [31:0] i_axis_tdata;
    logic [3:0]  i_axis_tkeep;
    logic [11:0] i_pkt_len;
    logic [15:0] i_frame_type;
    logic        o_axis_tvalid, o_axis_tlast, o_axis_tready, o_err, o_busy;
    logic [31:0] o_axis_tdata;
    logic [3:0]  o_axis_tkeep;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int err_seen;
    int first_cap_cyc;
    int last_start;

    logic [7:0]  pay [4200];
    logic [36:0] exp_q [$];
    logic [36:0] cap_q [$];

    fpjh_frag_send dut (
        .clk           (clk),
        .rst           (rst),
        .i_axis_tvalid (i_axis_tvalid),
        .i_axis_tdata  (i_axis_tdata),
        .i_axis_tkeep  (i_axis_tkeep),
        .i_axis_tlast  (i_axis_tlast),
        .i_axis_tready (i_axis_tready),
        .i_pkt_len     (i_pkt_len),
        .i_frame_type  (i_frame_type),
        .o_axis_tvalid (o_axis_tvalid),
        .o_axis_tdata  (o_axis_tdata),
        .o_axis_tkeep  (o_axis_tkeep),
        .o_axis_tlast  (o_axis_tlast),
        .o_axis_tready (o_axis_tready),
        .o_err         (o_err),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready pattern: 0 = always ready, 1 = toggle, 2 = random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       o_axis_tready = 1'b1;
            1:       o_axis_tready = ~o_axis_tready;
            default: o_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Output monitor: records every accepted beat and every error pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_axis_tvalid && o_axis_tready) begin
                if (first_cap_cyc < 0) first_cap_cyc = cyc;
                cap_q.push_back({o_axis_tdata, o_axis_tkeep, o_axis_tlast});
            end
            if (o_err) err_seen++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: header bytes, payload (zero past the bytes actually sent),
    // tail bytes, then plain 4-byte packing with tlast on the final beat.
    task automatic build_exp(input int L, input int act, input logic [15:0] typ);
        int n, fl, off;
        logic agg;
        logic [31:0] w, d;
        logic [3:0] k;
        logic [7:0] bq [$];
        exp_q.delete();
        agg = (L > FM);
        n = (L + FM - 1) / FM;
        for (int i = 0; i < n; i++) begin
            off = i * FM;
            fl = (L - off > FM) ? FM : L - off;
            bq.delete();
            w = {4'h0, 12'(fl), typ[15:1], agg};
            for (int b = 0; b < 4; b++) bq.push_back(w[31-8*b -: 8]);
            if (agg) begin
                w = {7'(i), 1'(i == n - 1), 12'h000, 12'(off)};
                for (int b = 0; b < 4; b++) bq.push_back(w[31-8*b -: 8]);
            end
            for (int j = 0; j < fl; j++) bq.push_back((off + j < act) ? pay[off + j] : 8'h00);
            for (int b = 0; b < 4; b++) bq.push_back(TAIL[31-8*b -: 8]);
            for (int b = 0; b < bq.size(); b += 4) begin
                d = '0;
                k = '0;
                for (int t = 0; t < 4; t++) begin
                    if (b + t < bq.size()) begin
                        d[31-8*t -: 8] = bq[b + t];
                        k[3-t] = 1'b1;
                    end
                end
                exp_q.push_back({d, k, 1'(b + 4 >= bq.size())});
            end
        end
    endtask

    // Sends act bytes with declared length L, then compares the captured frames.
    task automatic send_pkt(input string name, input int L, input int act, input logic [15:0] typ);
        int beats, b, stall, rdy_hi, e0, nmin;
        logic acc, done;
        logic [31:0] d;
        logic [3:0] k;
        for (int i = 0; i < act; i++) pay[i] = 8'($urandom);
        build_exp(L, act, typ);
        cap_q.delete();
        err_seen = 0;
        first_cap_cyc = -1;
        beats = (act + 3) / 4;
        b = 0;
        stall = 0;
        @(posedge clk);
        #1;
        i_pkt_len = 12'(L);
        i_frame_type = typ;
        last_start = cyc;
        while (b < beats && stall < 500) begin
            for (int t = 0; t < 4; t++) begin
                if (b * 4 + t < act) begin
                    d[31-8*t -: 8] = pay[b * 4 + t];
                    k[3-t] = 1'b1;
                end else begin
                    d[31-8*t -: 8] = 8'($urandom);
                    k[3-t] = 1'b0;
                end
            end
            i_axis_tdata = d;
            i_axis_tkeep = k;
            i_axis_tlast = (b == beats - 1);
            i_axis_tvalid = 1'b1;
            @(negedge clk);
            acc = i_axis_tready;
            @(posedge clk);
            #1;
            if (acc) begin
                b++;
                stall = 0;
            end else begin
                stall++;
            end
        end
        i_axis_tvalid = 1'b0;
        i_axis_tlast = 1'b0;
        chk({name, "_in_beats"}, 64'(b), 64'(beats));
        done = 1'b0;
        rdy_hi = 0;
        for (int w = 0; w < 6000 && !done; w++) begin
            @(negedge clk);
            if (i_axis_tready) rdy_hi++;
            if (cap_q.size() >= exp_q.size() && !o_busy && !o_axis_tvalid) done = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_rdy_low"}, 64'(rdy_hi), 64'd0);
        chk({name, "_err"}, 64'(err_seen), 64'(act != L));
        chk({name, "_nbeats"}, 64'(cap_q.size()), 64'(exp_q.size()));
        nmin = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            e0 = errors;
            chk($sformatf("%s_beat%0d", name, i), 64'(cap_q[i]), 64'(exp_q[i]));
            if (errors != e0) break;
        end
    endtask

    initial begin
        rst = 1'b1;
        i_axis_tvalid = 1'b0;
        i_axis_tlast = 1'b0;
        i_axis_tdata = '0;
        i_axis_tkeep = '0;
        i_pkt_len = '0;
        i_frame_type = '0;
        o_axis_tready = 1'b1;
        first_cap_cyc = -1;
        err_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(o_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(o_axis_tdata), 64'd0);
        chk("rst_tkeep", 64'(o_axis_tkeep), 64'd0);
        chk("rst_tlast", 64'(o_axis_tlast), 64'd0);
        chk("rst_tready", 64'(i_axis_tready), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        rst = 1'b0;

        send_pkt("l8", 8, 8, 16'h0010);
        chk("l8_latency", 64'(first_cap_cyc - last_start), 64'd1);
        chk("l8_word0", (cap_q.size() > 0) ? 64'(cap_q[0][36:5]) : 64'hDEAD, 64'h0008_0010);

        send_pkt("l5", 5, 5, 16'h1235);
        send_pkt("l1000", 1000, 1000, 16'hA5A4);
        rdy_mode = 1;
        send_pkt("l1000_stall", 1000, 1000, 16'hA5A4);
        rdy_mode = 0;
        send_pkt("short12", 12, 8, 16'h0042);
        send_pkt("long6", 6, 12, 16'h0077);
        send_pkt("l840", 840, 840, 16'h00F0);
        send_pkt("l841", 841, 841, 16'h00F1);
        send_pkt("l1680", 1680, 1680, 16'h00F2);
        rdy_mode = 2;
        send_pkt("l4095", 4095, 4095, 16'hFFFF);
        rdy_mode = 0;

        // Reset while payload is streaming.
        @(posedge clk);
        #1;
        i_pkt_len = 12'd40;
        i_frame_type = 16'h0100;
        i_axis_tdata = 32'h1122_3344;
        i_axis_tkeep = 4'b1111;
        i_axis_tlast = 1'b0;
        i_axis_tvalid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy", 64'(o_busy), 64'd1);
        rst = 1'b1;
        i_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_tvalid", 64'(o_axis_tvalid), 64'd0);
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_tready", 64'(i_axis_tready), 64'd0);
        rst = 1'b0;
        send_pkt("after_rst", 40, 40, 16'h0100);

        rdy_mode = 2;
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 2000);
            send_pkt($sformatf("rnd%0d", r), len, len, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
